// File: rtl/limb_serial_adder_ctrl.sv
// limb_serial_adder_ctrl: sequences a WIDTH-bit add through an external 16-bit adder, one limb per cycle
module limb_serial_adder_ctrl #(
  parameter int WIDTH = 64,
  parameter int LIMB  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [LIMB-1:0]  add_x1,
  output logic [LIMB-1:0]  add_x2,
  output logic             add_cin,
  input  logic [LIMB-1:0]  add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int NLIMB = WIDTH / LIMB;
  localparam int IW    = NLIMB > 1 ? $clog2(NLIMB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             run, last;
  assign run       = state_q == RUN;
  assign last      = idx_q == IW'(NLIMB - 1);
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign add_x1    = run ? a_q[LIMB*idx_q +: LIMB] : '0;
  assign add_x2    = run ? b_q[LIMB*idx_q +: LIMB] : '0;
  assign add_cin   = run & carry_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = in_a;
        b_d     = in_b;
        carry_d = in_cin;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[LIMB*idx_q +: LIMB] = add_s;
        carry_d = add_cout;
        idx_d   = last ? '0 : idx_q + 1'b1;
        // signed overflow: like-signed operands whose top sum bit disagrees with them
        if (last) begin
          cout_d  = add_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (add_s[LIMB-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
